// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_demux_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int LANE_IDX_W = 4;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry output register for a single demux lane, zero-gated when empty.
// Latency: a word loaded at edge N is presented after edge N.
// Backpressure: holds its word until popped; load together with pop replaces it.
module demux_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            if (load) begin
                data_q <= d;
            end
            vld_q <= load | (vld_q & ~pop);
        end
    end

    assign q     = vld_q ? data_q : '0;
    assign valid = vld_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NOUT stream demux with unicast, broadcast and out-of-range drop.
// Latency: one cycle from accept to out_valid on the target lane(s).
// Backpressure: in_ready follows the target lane (all lanes for broadcast); drops never stall.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NOUT  = 4,
    parameter int SELW  = $clog2(NOUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_bcast,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NOUT*WIDTH-1:0] out_data,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic [15:0]           drop_cnt
);

    lane_idx_t             sel_idx;
    logic [NOUT-1:0]       sel_hit;
    logic [NOUT-1:0]       free;
    logic [NOUT-1:0]       load;
    logic [NOUT-1:0]       pop;
    logic                  sel_ok;
    logic                  accept;
    logic                  drop;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    assign sel_idx = lane_idx_t'(in_sel);

    // An out-of-range select matches no lane, which is what flags it for dropping.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < NOUT; k++) begin
            sel_hit[k] = (sel_idx == lane_idx_t'(k));
        end
    end

    assign sel_ok   = |sel_hit;
    assign free     = ~out_valid | out_ready;
    assign in_ready = in_bcast ? (&free) : (sel_ok ? |(sel_hit & free) : 1'b1);
    assign accept   = in_valid & in_ready;
    assign load     = accept ? (in_bcast ? {NOUT{1'b1}} : sel_hit) : '0;
    assign pop      = out_valid & out_ready;
    assign drop     = accept & ~in_bcast & ~sel_ok;

    for (genvar k = 0; k < NOUT; k++) begin : g_lane
        demux_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .load (load[k]),
            .pop  (pop[k]),
            .d    (in_data),
            .q    (out_data[k*WIDTH +: WIDTH]),
            .valid(out_valid[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule
